// File: rtl/duty_ramp_controller_pkg.sv
// duty_ramp_controller_pkg: shared PWM constants and ramp FSM state encodings
//   DEFAULT_RESOLUTION : default width of duty command and PWM counter
//   ST_*               : ramp controller state encodings
package vehicle_pwm_pkg;
    localparam int DEFAULT_RESOLUTION = 4;
    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_RAMP_UP   = 2'd1;
    localparam logic [1:0] ST_RAMP_DOWN = 2'd2;
    localparam logic [1:0] ST_ESTOP     = 2'd3;
endpackage

// File: rtl/duty_ramp_controller_if.sv
// duty_ramp_controller_if: target duty valid/ready handshake
//   target_duty  : requested duty command (master -> slave)
//   target_valid : target_duty valid this cycle (master -> slave)
//   target_ready : slave accepts a target this cycle (slave -> master)
interface duty_ramp_controller_if
    import vehicle_pwm_pkg::*;
#(
    parameter int RESOLUTION = DEFAULT_RESOLUTION
);
    logic [RESOLUTION-1:0] target_duty;
    logic                  target_valid;
    logic                  target_ready;
    modport master (output target_duty, output target_valid, input target_ready);
    modport slave  (input target_duty, input target_valid, output target_ready);
endinterface

// File: rtl/duty_ramp_controller_divider.sv
// pwm_period_divider: counts PWM boundary ticks and emits one step per RAMP_PERIODS ticks
//   clk, reset : clock and synchronous active-high reset
//   tick       : PWM period boundary this cycle
//   clear      : restart the count from zero
//   enable     : count ticks only while ramping
//   step       : this edge completes RAMP_PERIODS ticks
module pwm_period_divider
    import vehicle_pwm_pkg::*;
#(
    parameter int RAMP_PERIODS = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic tick,
    input  logic clear,
    input  logic enable,
    output logic step
);
    localparam int CW = RAMP_PERIODS > 1 ? $clog2(RAMP_PERIODS) : 1;
    logic [CW-1:0] cnt_q, cnt_d;
    always_comb begin
        step  = enable && tick && (cnt_q == CW'(RAMP_PERIODS - 1));
        cnt_d = (clear || step) ? '0 : (enable && tick) ? cnt_q + 1'b1 : cnt_q;
    end
    always_ff @(posedge clk) begin
        if (reset)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end
endmodule

// File: rtl/duty_ramp_controller.sv
// duty_ramp_controller: ramps a registered PWM duty toward an accepted target one LSB at a time
//   clk, reset          : clock and synchronous active-high reset
//   tgt                 : target duty valid/ready handshake (slave side)
//   estop               : level-sensitive emergency stop, forces duty to zero
//   pwm_counter         : free-running counter of the downstream PWM stage
//   pulse_width_control : registered duty command to the PWM stage
//   ramping, at_target  : status (RAMP_UP/RAMP_DOWN, IDLE)
module duty_ramp_controller
    import vehicle_pwm_pkg::*;
#(
    parameter int RESOLUTION   = DEFAULT_RESOLUTION,
    parameter int RAMP_PERIODS = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    duty_ramp_controller_if.slave tgt,
    input  logic                  estop,
    input  logic [RESOLUTION-1:0] pwm_counter,
    output logic [RESOLUTION-1:0] pulse_width_control,
    output logic                  ramping,
    output logic                  at_target
);
    logic [1:0]            state_q, state_d;
    logic [RESOLUTION-1:0] duty_q, duty_d, target_q, target_d;
    logic                  tick, transfer, step, in_ramp;

    assign tick     = pwm_counter == {RESOLUTION{1'b1}};
    assign transfer = tgt.target_valid && tgt.target_ready;
    assign in_ramp  = state_q == ST_RAMP_UP || state_q == ST_RAMP_DOWN;

    // Divider is idle outside ramps, so a tick on the transfer edge is never counted.
    pwm_period_divider #(.RAMP_PERIODS(RAMP_PERIODS)) u_div (
        .clk    (clk),
        .reset  (reset),
        .tick   (tick),
        .clear  (estop || transfer),
        .enable (in_ramp),
        .step   (step)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            duty_q   <= '0;
            target_q <= '0;
        end else begin
            state_q  <= state_d;
            duty_q   <= duty_d;
            target_q <= target_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        duty_d   = duty_q;
        target_d = target_q;
        if (estop) begin
            state_d  = ST_ESTOP;
            duty_d   = '0;
            target_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (transfer) begin
                        target_d = tgt.target_duty;
                        state_d  = tgt.target_duty > duty_q ? ST_RAMP_UP :
                                   tgt.target_duty < duty_q ? ST_RAMP_DOWN : ST_IDLE;
                    end
                end
                ST_RAMP_UP, ST_RAMP_DOWN: begin
                    // Ramp direction guarantees target is strictly ahead, so a step cannot overshoot or wrap.
                    if (step) begin
                        duty_d  = state_q == ST_RAMP_UP ? duty_q + 1'b1 : duty_q - 1'b1;
                        state_d = duty_d == target_q ? ST_IDLE : state_q;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        tgt.target_ready    = state_q == ST_IDLE && !estop;
        pulse_width_control = duty_q;
        ramping             = in_ramp;
        at_target           = state_q == ST_IDLE;
    end
endmodule

// File: tb/tb_duty_ramp_controller.sv
// tb_duty_ramp_controller: scoreboard bench for duty_ramp_controller
module tb_duty_ramp_controller;
    import vehicle_pwm_pkg::*;
    localparam int RES = 4;
    localparam int P   = 2;
    localparam int TOP = (1 << RES) - 1;

    typedef struct {
        int obs;
        int duty;
        bit at;
        bit rmp;
    } exp_t;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           estop = 1'b0;
    logic [RES-1:0] pwm_counter;
    logic [RES-1:0] pulse_width_control;
    logic           ramping, at_target;

    int   edge_n = 0;
    int   checks = 0;
    int   failures = 0;
    int   cur_duty = 0;
    int   base_duty = 0;
    bit   mon_en = 0;
    logic [RES-1:0] last_pwc = '0;
    exp_t exp_q[$];
    exp_t cur_sched[$];

    duty_ramp_controller_if #(.RESOLUTION(RES)) tif ();

    duty_ramp_controller #(.RESOLUTION(RES), .RAMP_PERIODS(P)) dut (
        .clk                 (clk),
        .reset               (reset),
        .tgt                 (tif),
        .estop               (estop),
        .pwm_counter         (pwm_counter),
        .pulse_width_control (pulse_width_control),
        .ramping             (ramping),
        .at_target           (at_target)
    );

    always #5 clk = ~clk;
    always @(posedge clk) edge_n <= edge_n + 1;
    assign pwm_counter = edge_n[RES-1:0];

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_n);
        end
    endtask

    // Monitor: every change of the duty output must match the next scheduled change.
    always @(negedge clk) begin
        exp_t e;
        if (mon_en && pulse_width_control !== last_pwc) begin
            last_pwc = pulse_width_control;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_duty_change: got %0d expected no change (edge %0d)", pulse_width_control, edge_n);
            end else begin
                e = exp_q.pop_front();
                chk("duty_value", pulse_width_control, e.duty);
                chk("duty_edge", edge_n, e.obs);
                chk("at_target_on_change", at_target, e.at);
                chk("ramping_on_change", ramping, e.rmp);
            end
        end
    end

    // Reference: after acceptance at edge k0, every P-th PWM boundary (count==TOP) moves duty one LSB.
    task automatic schedule(int k0, int t);
        int   d = cur_duty;
        int   nt = 0;
        exp_t e;
        base_duty = cur_duty;
        cur_sched.delete();
        for (int k = k0 + 1; d != t; k++) begin
            if (k % (TOP + 1) == TOP) begin
                nt++;
                if (nt % P == 0) begin
                    d += (t > d) ? 1 : -1;
                    e = '{k + 1, d, d == t, d != t};
                    cur_sched.push_back(e);
                    exp_q.push_back(e);
                end
            end
        end
        cur_duty = t;
    endtask

    task automatic send_target(int t);
        int k0 = -1;
        bit exp_rdy;
        tif.target_duty  = RES'(t);
        tif.target_valid = 1'b1;
        for (int i = 0; i < 2000 && k0 < 0; i++) begin
            #3;
            exp_rdy = cur_sched.size() == 0 || cur_sched[$].obs <= edge_n;
            chk("target_ready", tif.target_ready, exp_rdy);
            if (tif.target_ready) k0 = edge_n;
            @(negedge clk);
            #1;
        end
        tif.target_valid = 1'b0;
        if (k0 < 0) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout: got no transfer expected transfer of %0d", t);
        end else
            schedule(k0, t);
    endtask

    task automatic settle();
        for (int i = 0; i < 1000 && exp_q.size() != 0; i++) begin
            @(negedge clk);
            #1;
        end
        chk("drain_pending", exp_q.size(), 0);
    endtask

    // Estop or reset applied before the next edge: pending steps vanish, duty drops to zero.
    task automatic abort(bit by_reset);
        int   k = edge_n;
        int   d = base_duty;
        exp_t e;
        foreach (cur_sched[i]) if (cur_sched[i].obs <= k) d = cur_sched[i].duty;
        while (exp_q.size() > 0 && exp_q[$].obs > k) void'(exp_q.pop_back());
        if (d != 0) begin
            e = '{k + 1, 0, by_reset, 1'b0};
            exp_q.push_back(e);
        end
        cur_sched.delete();
        cur_duty  = 0;
        base_duty = 0;
        if (by_reset) reset = 1'b1;
        else estop = 1'b1;
    endtask

    task automatic step_cycle();
        @(negedge clk);
        #1;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int r;
        tif.target_valid = 1'b0;
        tif.target_duty  = '0;
        repeat (3) @(negedge clk);
        chk("reset_pwc", pulse_width_control, 0);
        chk("reset_at_target", at_target, 1);
        chk("reset_ramping", ramping, 0);
        chk("reset_ready", tif.target_ready, 1);
        #1;
        reset    = 1'b0;
        last_pwc = '0;
        mon_en   = 1'b1;

        send_target(3);
        send_target(1);
        settle();

        send_target(3);
        while (edge_n < cur_sched[0].obs) step_cycle();
        abort(1'b0);
        step_cycle();
        chk("estop_pwc", pulse_width_control, 0);
        chk("estop_ready", tif.target_ready, 0);
        chk("estop_ramping", ramping, 0);
        chk("estop_at_target", at_target, 0);
        estop = 1'b0;
        step_cycle();
        chk("release_at_target", at_target, 1);
        chk("release_ready", tif.target_ready, 1);
        chk("release_pwc", pulse_width_control, 0);

        send_target(15);
        settle();
        chk("full_scale_pwc", pulse_width_control, 15);
        send_target(15);
        chk("equal_target_ramping", ramping, 0);
        repeat (40) step_cycle();
        chk("equal_target_at_target", at_target, 1);
        chk("equal_target_pwc", pulse_width_control, 15);

        abort(1'b1);
        step_cycle();
        reset = 1'b0;
        send_target(6);
        while (edge_n < cur_sched[1].obs) step_cycle();
        chk("pre_reset_ramping", ramping, 1);
        abort(1'b1);
        step_cycle();
        chk("midramp_reset_at_target", at_target, 1);
        chk("midramp_reset_ramping", ramping, 0);
        chk("midramp_reset_pwc", pulse_width_control, 0);
        reset = 1'b0;

        abort(1'b0);
        tif.target_duty  = RES'(9);
        tif.target_valid = 1'b1;
        #3;
        chk("estop_valid_ready", tif.target_ready, 0);
        step_cycle();
        estop            = 1'b0;
        tif.target_valid = 1'b0;
        step_cycle();
        step_cycle();
        chk("estop_valid_no_ramp", ramping, 0);
        chk("estop_valid_at_target", at_target, 1);

        repeat (25) begin
            send_target($urandom_range(0, TOP));
            r = $urandom_range(0, 9);
            if (r <= 1) begin
                repeat ($urandom_range(0, 80)) step_cycle();
                abort(r[0]);
                step_cycle();
                reset = 1'b0;
                estop = 1'b0;
                step_cycle();
            end else if (r < 6)
                settle();
        end
        settle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
